// File: rtl/io_write_arbiter.sv
// Three-requester round-robin arbiter feeding single-cycle writes into the
// output-port register block; illegal word addresses are granted but flagged.

module io_write_lane #(
   parameter logic [5:0] PORT_FIRST = 6'h20,
   parameter logic [5:0] PORT_LAST  = 6'h22
) (
   input  logic [5:0] word,
   output logic       legal
);
   assign legal = (word >= PORT_FIRST) && (word <= PORT_LAST);
endmodule

module io_write_arbiter #(
   parameter logic [5:0] PORT_FIRST = 6'h20,
   parameter logic [5:0] PORT_LAST  = 6'h22
) (
   input  logic        io_clk,
   input  logic        clr,
   input  logic [2:0]  req,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] addr2,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic [2:0]  gnt,
   output logic        err,
   output logic [31:0] io_addr,
   output logic [31:0] io_data,
   output logic        write_io_enable,
   output logic        busy
);
   localparam int NUM_REQ = 3;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t                         state;
   logic   [1:0]                   ptr;
   logic   [NUM_REQ-1:0][31:0]     addr_vec;
   logic   [NUM_REQ-1:0][31:0]     data_vec;
   logic   [NUM_REQ-1:0]           legal;
   logic   [1:0]                   win;
   logic   [1:0]                   ptr_nxt;
   logic                           found;

   assign addr_vec = {addr2, addr1, addr0};
   assign data_vec = {data2, data1, data0};

   // Legality only looks at the word address; byte offset and page bits pass through.
   genvar i;
   generate
      for (i = 0; i < NUM_REQ; i++) begin : g_lane
         io_write_lane #(.PORT_FIRST(PORT_FIRST), .PORT_LAST(PORT_LAST)) u_lane (
            .word  (addr_vec[i][7:2]),
            .legal (legal[i])
         );
      end
   endgenerate

   // Search P, P+1, P+2 (mod 3); first requester found wins.
   always_comb begin
      logic [2:0] idx;
      win   = 2'd0;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + 3'(k);
         if (idx >= 3'd3) idx = idx - 3'd3;
         if (!found && req[idx[1:0]]) begin
            found = 1'b1;
            win   = idx[1:0];
         end
      end
      ptr_nxt = (win == 2'd2) ? 2'd0 : win + 2'd1;
   end

   always_ff @(posedge io_clk or posedge clr) begin
      if (clr) begin
         state           <= IDLE;
         ptr             <= 2'd0;
         gnt             <= 3'b000;
         err             <= 1'b0;
         write_io_enable <= 1'b0;
         busy            <= 1'b0;
         io_addr         <= 32'd0;
         io_data         <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               gnt             <= 3'b000;
               err             <= 1'b0;
               write_io_enable <= 1'b0;
               busy            <= 1'b0;
               if (found) begin
                  state           <= WRITE;
                  gnt             <= 3'b001 << win;
                  io_addr         <= addr_vec[win];
                  io_data         <= data_vec[win];
                  write_io_enable <= legal[win];
                  err             <= ~legal[win];
                  busy            <= 1'b1;
                  ptr             <= ptr_nxt;
               end
            end
            WRITE: begin
               // Pending requests wait; this cycle only retires the write.
               state           <= IDLE;
               gnt             <= 3'b000;
               err             <= 1'b0;
               write_io_enable <= 1'b0;
               busy            <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_io_write_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor pops
// and compares whenever a grant appears.

module tb_io_write_arbiter;
   logic        io_clk = 1'b0;
   logic        clr = 1'b0;
   logic [2:0]  req = 3'b000;
   logic [31:0] addr0 = 0, addr1 = 0, addr2 = 0;
   logic [31:0] data0 = 0, data1 = 0, data2 = 0;
   logic [2:0]  gnt;
   logic        err;
   logic [31:0] io_addr, io_data;
   logic        write_io_enable, busy;

   typedef struct packed {
      logic [2:0]  g;
      logic        e;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   logic prev_gnt = 1'b0;

   io_write_arbiter dut (
      .io_clk(io_clk), .clr(clr), .req(req),
      .addr0(addr0), .addr1(addr1), .addr2(addr2),
      .data0(data0), .data1(data1), .data2(data2),
      .gnt(gnt), .err(err), .io_addr(io_addr), .io_data(io_data),
      .write_io_enable(write_io_enable), .busy(busy)
   );

   always #5 io_clk = ~io_clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else passed++;
   endtask

   task automatic push(input logic [2:0] g, input logic e, input logic [31:0] a, input logic [31:0] d);
      exp_t x;
      x.g = g; x.e = e; x.w = ~e; x.a = a; x.d = d;
      q.push_back(x);
   endtask

   // Keep req held until every queued grant has been seen, then drop it.
   task automatic drain(input int budget);
      int cyc = 0;
      while (q.size() != 0 && cyc < budget) begin
         @(negedge io_clk); #1;
         cyc++;
      end
      chk("drain_timeout", 64'(q.size()), 64'd0);
      req = 3'b000;
   endtask

   task automatic single(input int r, input logic [31:0] a, input logic [31:0] d, input logic e);
      @(posedge io_clk); #1;
      case (r)
         0: begin addr0 = a; data0 = d; end
         1: begin addr1 = a; data1 = d; end
         default: begin addr2 = a; data2 = d; end
      endcase
      req = 3'b001 << r;
      push(3'b001 << r, e, a, d);
      drain(10);
      repeat (2) @(posedge io_clk);
   endtask

   always @(negedge io_clk) begin
      if (gnt != 3'b000) begin
         exp_t x;
         chk("back_to_back_gnt", 64'(prev_gnt), 64'd0);
         if (q.size() == 0) begin
            chk("unexpected_gnt", 64'(gnt), 64'd0);
         end else begin
            x = q.pop_front();
            chk("gnt_err_we_busy", {58'd0, gnt, err, write_io_enable, busy}, {58'd0, x.g, x.e, x.w, 1'b1});
            chk("io_addr", {32'd0, io_addr}, {32'd0, x.a});
            chk("io_data", {32'd0, io_data}, {32'd0, x.d});
         end
         prev_gnt <= 1'b1;
      end else begin
         chk("idle_strobes", {61'd0, err, write_io_enable, busy}, 64'd0);
         prev_gnt <= 1'b0;
      end
   end

   initial begin
      #1 clr = 1'b1;
      #3;
      chk("reset_outs", {58'd0, gnt, err, write_io_enable, busy}, 64'd0);
      chk("reset_io", {io_addr, io_data}, 64'd0);
      repeat (2) @(posedge io_clk);
      #1 clr = 1'b0;

      // single request, one-edge latency, strobes clear next cycle
      @(posedge io_clk); #1;
      addr0 = 32'h80; data0 = 32'd57; req = 3'b001;
      push(3'b001, 1'b0, 32'h80, 32'd57);
      @(posedge io_clk); #1;
      chk("single_latency", 64'(gnt), 64'd1);
      req = 3'b000;
      @(posedge io_clk); #1;
      chk("single_after", {58'd0, gnt, err, write_io_enable, busy}, 64'd0);
      repeat (2) @(posedge io_clk); #1;
      chk("io_hold", {io_addr, io_data}, {32'h80, 32'd57});

      // illegal address from requester 1; pointer moves to 2
      single(1, 32'h8C, 32'h1111, 1'b1);

      // contention from P=2, then from P=0
      @(posedge io_clk); #1;
      addr0 = 32'h80; addr1 = 32'h84; addr2 = 32'h88;
      data0 = 32'hA0; data1 = 32'hA1; data2 = 32'hA2;
      req = 3'b111;
      push(3'b100, 1'b0, 32'h88, 32'hA2);
      push(3'b001, 1'b0, 32'h80, 32'hA0);
      push(3'b010, 1'b0, 32'h84, 32'hA1);
      push(3'b100, 1'b0, 32'h88, 32'hA2);
      drain(20);
      @(posedge io_clk); #1;
      req = 3'b111;
      push(3'b001, 1'b0, 32'h80, 32'hA0);
      push(3'b010, 1'b0, 32'h84, 32'hA1);
      push(3'b100, 1'b0, 32'h88, 32'hA2);
      push(3'b001, 1'b0, 32'h80, 32'hA0);
      drain(20);
      repeat (2) @(posedge io_clk);

      // window boundaries and ignored address bits
      single(0, 32'h80,        32'hB0, 1'b0);
      single(2, 32'h88,        32'hB1, 1'b0);
      single(1, 32'h7C,        32'hB2, 1'b1);
      single(0, 32'h8C,        32'hB3, 1'b1);
      single(2, 32'hFFFF_FF84, 32'hB4, 1'b0);
      single(1, 32'h83,        32'hB5, 1'b0);

      // req0 raised and withdrawn while requester 1 is writing
      @(posedge io_clk); #1;
      addr1 = 32'h84; data1 = 32'hC1; req = 3'b010;
      push(3'b010, 1'b0, 32'h84, 32'hC1);
      @(posedge io_clk); #1;
      req = 3'b001;
      @(negedge io_clk); #1;
      req = 3'b000;
      repeat (3) @(posedge io_clk); #1;
      chk("withdraw_no_write", {58'd0, gnt, err, write_io_enable, busy}, 64'd0);
      chk("withdraw_queue", 64'(q.size()), 64'd0);

      // reset during WRITE (pointer sits at 2 before this grant)
      @(posedge io_clk); #1;
      addr1 = 32'h84; data1 = 32'hD1; req = 3'b010;
      @(posedge io_clk); #2;
      clr = 1'b1;
      #1;
      chk("midwrite_strobes", {58'd0, gnt, err, write_io_enable, busy}, 64'd0);
      chk("midwrite_io", {io_addr, io_data}, 64'd0);
      #1;
      clr = 1'b0;
      addr1 = 32'h88; data1 = 32'hE1; addr2 = 32'h80; data2 = 32'hE2;
      req = 3'b110;
      push(3'b010, 1'b0, 32'h88, 32'hE1);
      push(3'b100, 1'b0, 32'h80, 32'hE2);
      drain(20);
      repeat (3) @(posedge io_clk);

      chk("final_queue_empty", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/io_write_arbiter.md
IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

Interface
REQ-001 Parameter PORT_FIRST, default 6'h20, lowest legal output-port word address (addr[7:2]).
REQ-002 Parameter PORT_LAST, default 6'h22, highest legal output-port word address (addr[7:2]).
REQ-003 io_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 req  input  3  per-requester write request, level, held until matching gnt bit seen.
REQ-006 addr0, addr1, addr2  input  32 each  requester write address, stable while req bit high.
REQ-007 data0, data1, data2  input  32 each  requester write data, stable while req bit high.
REQ-008 gnt  output  3  one-hot, one-cycle acceptance pulse to the winning requester.
REQ-009 err  output  1  one-cycle pulse, coincident with gnt, when the accepted address is outside the legal window.
REQ-010 io_addr  output  32  registered address to the output-port register block.
REQ-011 io_data  output  32  registered data to the output-port register block.
REQ-012 write_io_enable  output  1  registered write strobe to the output-port register block.
REQ-013 busy  output  1  high while the FSM is in WRITE.

Function
REQ-014 FSM has two states, IDLE and WRITE; all outputs are registered.
REQ-015 IDLE: if any req bit set, select winner by round-robin, load io_addr/io_data from that requester, assert gnt[winner], go to WRITE at the same edge.
REQ-016 IDLE with req == 0: stay in IDLE; gnt, err, write_io_enable, busy = 0; io_addr/io_data hold last values.
REQ-017 WRITE lasts exactly one cycle, then returns unconditionally to IDLE; no grant is issued from WRITE, even with req pending.
REQ-018 Outputs in WRITE: gnt and busy high; write_io_enable = 1 iff accepted addr[7:2] lies in [PORT_FIRST, PORT_LAST], else write_io_enable = 0 and err = 1.
REQ-019 Window check uses addr[7:2] only; addr[31:8] and addr[1:0] are ignored for legality but passed unchanged on io_addr.
REQ-020 Latency: req high before edge N (FSM in IDLE) -> gnt/write_io_enable high from edge N to edge N+1.
REQ-021 Throughput: at most one accepted request per 2 cycles; a requester dropping req at edge N+1 is never double-granted.
REQ-022 Round-robin: 2-bit pointer P (0..2) is highest priority; search order P, P+1, P+2 mod 3; after granting i, P becomes (i+1) mod 3.
REQ-023 Pointer wrap: granting requester 2 sets P to 0.
REQ-024 Rejected (err) requests still count as grants and advance P.
REQ-025 A req bit dropped before acceptance is simply not considered; no error, no state change.
REQ-026 gnt is always one-hot or zero; err is never high without gnt.

Reset
REQ-027 clr high: immediately, independent of io_clk, state = IDLE, P = 0, gnt = 0, err = 0, write_io_enable = 0, busy = 0, io_addr = 0, io_data = 0.
REQ-028 clr asserted during WRITE aborts the write: write_io_enable drops asynchronously; the in-flight request is lost and its requester must re-request.
REQ-029 First edge after clr deasserts evaluates requests normally from IDLE with P = 0.

Verification
REQ-030 Single: req=3'b001, addr0=32'h80, data0=32'd57 -> one cycle later gnt=001, write_io_enable=1, io_addr=32'h80, io_data=57, err=0; next cycle all strobes 0.
REQ-031 Contention: req=3'b111 held, all addresses legal -> grants in order 001, 010, 100, 001 on alternating cycles; write_io_enable never high two consecutive cycles.
REQ-032 Illegal address: req=3'b010, addr1=32'h8C -> gnt=010, err=1, write_io_enable=0; P advances to 2.
REQ-033 Boundaries: addr 32'h80 and 32'h88 accepted; 32'h7C and 32'h8C flagged err; addr 32'hFFFF_FF84 accepted with io_addr unchanged.
REQ-034 Reset mid-write: clr pulsed during WRITE -> write_io_enable, gnt, busy, io_addr, io_data = 0 before next io_clk edge; after release, req=3'b110 grants requester 1 first (P = 0).
REQ-035 Request withdrawal: req0 raised then dropped while FSM in WRITE for requester 1 -> requester 0 receives no gnt; no spurious write.
